cbu_timer_sched: RTL and testbench
==================================

# cbu_timer_sched

Round-robin scheduler that shares one cascaded up-counter among up to NREQ requesters, each asking for a timeout of LEN clock cycles. It sits between the requesting control blocks and a chain of 4-bit loadable up-counter slices with carry-in and carry-out. It grants the counter, loads it, sequences enable, detects terminal count and returns a one-cycle completion pulse to the granted requester.

## Interface
- NREQ, 4: number of requesters, 2..8
- WIDTH, 8: counter width in bits; a multiple of 4, from 4 to 16
- CLK  in  1  clock; all state changes on the rising edge
- CS  in  1  reset; synchronous, active-high
- REQ  in  NREQ  per-requester request level; held until DONE, or dropped to cancel
- LEN  in  NREQ*WIDTH  packed timeout lengths; slice i = LEN[i*WIDTH +: WIDTH]; sampled in LOAD
- HOLD  in  1  pause; when high, RUN does not increment
- GNT  out  NREQ  one-hot grant, registered
- DONE  out  NREQ  one-hot completion pulse, registered, 1 cycle
- BUSY  out  1  high in any state other than IDLE
- CNT  out  WIDTH  current counter value, for observation

## Operation
- States:
  - IDLE: GNT=0. If any REQ bit is high, latch the winner index g, set GNT[g] and go to LOAD.
  - LOAD: counter <= ~LEN[g], then go to RUN.
  - RUN: if REQ[g] is low, cancel: go to IDLE with no DONE and clear GNT. Else if CNT is all ones, go to DONE. Else if HOLD is low, increment the counter.
  - DONE: DONE[g]=1, clear GNT, move the pointer to g+1 mod NREQ, go to IDLE.
- Arbitration is round-robin. Search starts at the pointer and wraps. After reset the pointer is 0.
- A cancel also moves the pointer to g+1.
- Terminal detect is the cascaded carry of all slices (all ones). It is checked in RUN regardless of HOLD.
- Load value ~LEN means exactly LEN increments reach all ones. LEN=0 loads all ones and finishes with no increments. No special case is needed.
- The counter never wraps inside a job; the maximum LEN is 2^WIDTH−1.
- LEN changes after LOAD have no effect. REQ changes from non-granted requesters have no effect until IDLE.
- CS at any point, including mid-RUN:
  - state goes to IDLE and the pointer to 0
  - GNT=0, DONE=0, BUSY=0, CNT=0
  - no DONE is issued for the interrupted job

## Timing
- Edge 1 samples REQ in IDLE; GNT is high after edge 1.
- Edge 2 loads the counter; CNT=~LEN after edge 2.
- With HOLD low, increments happen on edges 3..LEN+2.
- Edge LEN+3 enters DONE; DONE is high for the single cycle after edge LEN+3.
- Edge LEN+4 returns to IDLE. The next grant is visible after edge LEN+5.
- Each cycle HOLD is high in RUN (before terminal) delays DONE by one cycle.
- A cancel takes effect on the first RUN edge that sees REQ[g] low. GNT is low after that edge.
- DONE and GNT are never high together for the same index.

## Structure
- Package cbu_sched_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE)
  - the slice width constant (4)
  - a function for the next round-robin index
- Sub-module cbu_cnt_slice is a 4-bit up-counter with synchronous clear, load, enable, CAI and CAO. It is instantiated WIDTH/4 times, with CAO of slice k feeding CAI of slice k+1.
- Terminal detect is the CAO of the top slice with the first CAI tied high.

## Test plan
- Single job, WIDTH=8: REQ=0001, LEN[0]=5, HOLD=0.
  - GNT=0001 after edge 1.
  - CNT=0xFA after edge 2.
  - DONE=0001 in the cycle after edge 8 only; BUSY low after edge 9.
- Fairness: REQ=0101 held, all LEN=2 → grant order 0,2,0,2, each DONE after its own job. REQ=1111 → order 0,1,2,3,0.
- Boundaries:
  - LEN=0 → DONE after edge 3.
  - LEN=255 (WIDTH=8) → CNT=0x00 after edge 2, carry crosses the slice boundary at 0x0F→0x10, DONE after edge 258.
- HOLD: LEN=4 with HOLD high for 3 RUN cycles → DONE after edge 10 instead of edge 7.
- Cancel: REQ[1] dropped mid-RUN → GNT=0 after the next edge, DONE never high. A pending REQ[2] is granted next.
- Reset mid-RUN: CS high for 1 cycle →
  - all outputs 0 after that edge, no DONE
  - with REQ=0011 held, the next grant is index 0

Source files
------------

// File: rtl/cbu_sched_pkg.sv
// rtl/cbu_sched_pkg.sv - shared types, constants and round-robin helpers for the timer scheduler
package cbu_sched_pkg;

    localparam int SLICE_W = 4;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
        return (int'(idx) + 1 >= n) ? 3'd0 : idx + 3'd1;
    endfunction

    // First requester at or after ptr, wrapping at n; returns ptr when none is set.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr,
                                           input int n);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/cbu_cnt_slice.sv
// rtl/cbu_cnt_slice.sv - 4-bit loadable up-counter slice with carry-in and carry-out
module cbu_cnt_slice
    import cbu_sched_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               load,
    input  logic               en,
    input  logic               cai,
    input  logic [SLICE_W-1:0] d,
    output logic [SLICE_W-1:0] q,
    output logic               cao
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en && cai) begin
            q <= q + SLICE_W'(1);
        end
    end

    // Carry is independent of en so the chain also serves as the terminal detector.
    assign cao = cai & (&q);

endmodule

// File: rtl/cbu_timer_sched.sv
// rtl/cbu_timer_sched.sv - round-robin scheduler sharing one cascaded counter among NREQ requesters
module cbu_timer_sched
    import cbu_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  CS,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] LEN,
    input  logic                  HOLD,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       DONE,
    output logic                  BUSY,
    output logic [WIDTH-1:0]      CNT
);

    localparam int NSL = WIDTH / SLICE_W;

    state_t               state;
    logic [2:0]           g;
    logic [2:0]           ptr;
    logic [2:0]           win;
    logic [MAX_REQ-1:0]   req_ext;
    logic [MAX_REQ-1:0]   win_oh;
    logic [MAX_REQ-1:0]   g_oh;
    logic [WIDTH-1:0]     load_val;
    logic [NSL:0]         carry;
    logic                 tc;
    logic                 cnt_load;
    logic                 cnt_en;

    assign req_ext  = MAX_REQ'(REQ);
    assign win      = rr_pick(req_ext, ptr, NREQ);
    assign win_oh   = MAX_REQ'(1) << win;
    assign g_oh     = MAX_REQ'(1) << g;
    // Loading the complement makes exactly LEN increments land on all ones.
    assign load_val = ~LEN[int'(g)*WIDTH +: WIDTH];

    assign carry[0] = 1'b1;
    assign tc       = carry[NSL];
    assign cnt_load = (state == ST_LOAD);
    assign cnt_en   = (state == ST_RUN) && req_ext[g] && !tc && !HOLD;
    assign BUSY     = (state != ST_IDLE);

    for (genvar k = 0; k < NSL; k++) begin : g_slice
        cbu_cnt_slice u_slice (
            .clk  (CLK),
            .clr  (CS),
            .load (cnt_load),
            .en   (cnt_en),
            .cai  (carry[k]),
            .d    (load_val[k*SLICE_W +: SLICE_W]),
            .q    (CNT[k*SLICE_W +: SLICE_W]),
            .cao  (carry[k+1])
        );
    end

    always_ff @(posedge CLK) begin
        if (CS) begin
            state <= ST_IDLE;
            g     <= '0;
            ptr   <= '0;
            GNT   <= '0;
            DONE  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    DONE <= '0;
                    if (|REQ) begin
                        g     <= win;
                        GNT   <= win_oh[NREQ-1:0];
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    // Cancel wins over terminal count on the same edge.
                    if (!req_ext[g]) begin
                        GNT   <= '0;
                        ptr   <= rr_next(g, NREQ);
                        state <= ST_IDLE;
                    end else if (tc) begin
                        GNT   <= '0;
                        DONE  <= g_oh[NREQ-1:0];
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    DONE  <= '0;
                    ptr   <= rr_next(g, NREQ);
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbu_timer_sched.sv
// tb/tb_cbu_timer_sched.sv - randomized self-checking bench for cbu_timer_sched
module tb_cbu_timer_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic                  CLK = 1'b0;
    logic                  CS;
    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] LEN;
    logic                  HOLD;
    logic [NREQ-1:0]       GNT;
    logic [NREQ-1:0]       DONE;
    logic                  BUSY;
    logic [WIDTH-1:0]      CNT;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;
    int lens[NREQ];

    cbu_timer_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CLK  (CLK),
        .CS   (CS),
        .REQ  (REQ),
        .LEN  (LEN),
        .HOLD (HOLD),
        .GNT  (GNT),
        .DONE (DONE),
        .BUSY (BUSY),
        .CNT  (CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_lens();
        for (int i = 0; i < NREQ; i++) LEN[i*WIDTH +: WIDTH] = WIDTH'(lens[i]);
    endtask

    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic do_reset();
        CS = 1'b1;
        tick();
        CS = 1'b0;
        mptr = 0;
        check("rst_gnt", 32'(GNT), 0);
        check("rst_busy", 32'(BUSY), 0);
    endtask

    // One job from IDLE. hold_n>=0 holds HOLD high for the first hold_n RUN cycles,
    // otherwise HOLD is random at hold_pct. abort_at>=0 cancels (or resets) at that RUN step.
    task automatic do_job(input logic [NREQ-1:0] req, input int hold_n, input int hold_pct,
                          input int abort_at, input bit abort_rst, input bit scramble);
        int  w;
        int  rem;
        int  base;
        bit  h;
        bit  fin;
        REQ  = req;
        HOLD = 1'b0;
        apply_lens();
        w = pick(req);
        tick();
        check("gnt", 32'(GNT), 32'(1 << w));
        check("busy_run", 32'(BUSY), 1);
        check("done_early", 32'(DONE), 0);
        tick();
        base = (~lens[w]) & MASK;
        check("load_cnt", 32'(CNT), 32'(base));
        if (scramble) begin
            for (int i = 0; i < NREQ; i++) LEN[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        rem = lens[w];
        fin = 1'b0;
        for (int s = 0; s < 400 && !fin; s++) begin
            h    = (hold_n >= 0) ? (s < hold_n) : ($urandom_range(99) < hold_pct);
            HOLD = h;
            if (s == abort_at) begin
                if (abort_rst) CS = 1'b1;
                else REQ[w] = 1'b0;
                tick();
                CS   = 1'b0;
                HOLD = 1'b0;
                check("abort_gnt", 32'(GNT), 0);
                check("abort_done", 32'(DONE), 0);
                check("abort_busy", 32'(BUSY), 0);
                if (abort_rst) begin
                    check("abort_cnt", 32'(CNT), 0);
                    mptr = 0;
                end else begin
                    mptr = (w + 1) % NREQ;
                end
                return;
            end
            if (rem == 0) begin
                tick();
                check("done", 32'(DONE), 32'(1 << w));
                check("gnt_at_done", 32'(GNT), 0);
                fin = 1'b1;
            end else begin
                tick();
                if (!h) rem--;
                check("run_cnt", 32'(CNT), 32'((base + lens[w] - rem) & MASK));
                check("run_done", 32'(DONE), 0);
            end
        end
        if (!fin) check("done_timeout", 0, 1);
        HOLD = 1'b0;
        tick();
        check("done_pulse", 32'(DONE), 0);
        check("idle_busy", 32'(BUSY), 0);
        check("idle_gnt", 32'(GNT), 0);
        mptr = (w + 1) % NREQ;
    endtask

    initial begin
        CS   = 1'b1;
        REQ  = '0;
        HOLD = 1'b0;
        LEN  = '0;
        tick();
        tick();
        check("reset_gnt", 32'(GNT), 0);
        check("reset_done", 32'(DONE), 0);
        check("reset_busy", 32'(BUSY), 0);
        check("reset_cnt", 32'(CNT), 0);
        CS = 1'b0;

        for (int i = 0; i < NREQ; i++) lens[i] = 5;
        do_job(4'b0001, 0, 0, -1, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < NREQ; i++) lens[i] = 2;
        repeat (4) do_job(4'b0101, 0, 0, -1, 1'b0, 1'b0);
        do_reset();
        repeat (5) do_job(4'b1111, 0, 0, -1, 1'b0, 1'b0);

        lens[0] = 0;
        lens[1] = 255;
        do_reset();
        do_job(4'b0001, 0, 0, -1, 1'b0, 1'b0);
        do_job(4'b0010, 0, 0, -1, 1'b0, 1'b0);

        lens[2] = 4;
        do_job(4'b0100, 3, 0, -1, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < NREQ; i++) lens[i] = 6;
        do_job(4'b0110, 0, 0, 2, 1'b0, 1'b0);
        do_job(4'b0101, 0, 0, -1, 1'b0, 1'b0);

        do_job(4'b0001, 0, 0, -1, 1'b0, 1'b0);
        do_job(4'b0011, 0, 0, 3, 1'b1, 1'b0);
        do_job(4'b0011, 0, 0, -1, 1'b0, 1'b0);

        for (int j = 0; j < 25; j++) begin
            int  ab;
            bit  rst;
            for (int i = 0; i < NREQ; i++) lens[i] = $urandom_range(20);
            ab  = ($urandom_range(4) == 0) ? $urandom_range(10) : -1;
            rst = $urandom_range(1) == 1;
            do_job(NREQ'($urandom_range(15, 1)), -1, 30, ab, rst, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
